// File: rtl/val2_seq_ctrl.sv
// ============================================================================
//  Module   : val2_seq_ctrl
//  Purpose  : Multi-cycle Val2 (shifter operand) generator with busy/stall.
//  Config   : define VAL2_BARREL_EN for single-cycle barrel computation.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module val2_seq_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] RMVal,
   input  logic             Imm,
   input  logic             LdOrStr,
   input  logic [11:0]      ShiftOperand,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      OP_LSL  = 3'd0,
      OP_LSR  = 3'd1,
      OP_ASR  = 3'd2,
      OP_ROR  = 3'd3,
      OP_ROR2 = 3'd4
   } op_t;

   state_t           state_q, state_d;
   op_t              op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [4:0]       cnt_q, cnt_d;
   logic             valid_q, valid_d;

   logic [WIDTH-1:0] base_w;
   logic [4:0]       amt_w;
   op_t              op_w;
   logic [WIDTH-1:0] load_acc_w;
   logic [4:0]       load_cnt_w;

   // LdOrStr outranks Imm; register-specified shifts degrade to a plain Rm pass.
   always_comb begin
      base_w = RMVal;
      amt_w  = 5'd0;
      op_w   = OP_LSL;
      if (LdOrStr) begin
         base_w = {{(WIDTH-12){1'b0}}, ShiftOperand};
      end else if (Imm) begin
         base_w = {{(WIDTH-8){1'b0}}, ShiftOperand[7:0]};
         amt_w  = {1'b0, ShiftOperand[11:8]};
         op_w   = OP_ROR2;
      end else if (!ShiftOperand[4]) begin
         amt_w = ShiftOperand[11:7];
         op_w  = op_t'({1'b0, ShiftOperand[6:5]});
      end
   end

   function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] a, input op_t op);
      case (op)
         OP_LSL:  step1 = {a[WIDTH-2:0], 1'b0};
         OP_LSR:  step1 = {1'b0, a[WIDTH-1:1]};
         OP_ASR:  step1 = {a[WIDTH-1], a[WIDTH-1:1]};
         OP_ROR:  step1 = {a[0], a[WIDTH-1:1]};
         OP_ROR2: step1 = {a[1:0], a[WIDTH-1:2]};
         default: step1 = a;
      endcase
   endfunction

`ifdef VAL2_BARREL_EN
   function automatic logic [WIDTH-1:0] full_shift(input logic [WIDTH-1:0] a,
                                                    input op_t op, input logic [4:0] amt);
      logic [5:0] sh;
      sh = (op == OP_ROR2) ? {amt, 1'b0} : {1'b0, amt};
      case (op)
         OP_LSL:  full_shift = a << sh;
         OP_LSR:  full_shift = a >> sh;
         OP_ASR:  full_shift = $unsigned($signed(a) >>> sh);
         default: full_shift = (a >> sh) | (a << (6'(WIDTH) - sh));
      endcase
   endfunction

   assign load_acc_w = full_shift(base_w, op_w, amt_w);
   assign load_cnt_w = 5'd0;
`else
   assign load_acc_w = base_w;
   assign load_cnt_w = amt_w;
`endif

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      valid_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               acc_d   = load_acc_w;
               cnt_d   = load_cnt_w;
               op_d    = op_w;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (flush) begin
               state_d = IDLE;
            end else if (cnt_q != 5'd0) begin
               acc_d = step1(acc_q, op_q);
               cnt_d = cnt_q - 5'd1;
            end else begin
               result_d = acc_q;
               valid_d  = 1'b1;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= OP_LSL;
         acc_q    <= '0;
         cnt_q    <= 5'd0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   assign result       = result_q;
   assign result_valid = valid_q;
   assign busy         = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_val2_seq_ctrl.sv
// ============================================================================
//  Module   : tb_val2_seq_ctrl
//  Purpose  : Directed vector bench for val2_seq_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_val2_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, flush, Imm, LdOrStr;
   logic [31:0] RMVal;
   logic [11:0] ShiftOperand;
   wire  [31:0] result;
   wire         result_valid, busy;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   val2_seq_ctrl #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .flush(flush),
      .RMVal(RMVal), .Imm(Imm), .LdOrStr(LdOrStr), .ShiftOperand(ShiftOperand),
      .result(result), .result_valid(result_valid), .busy(busy)
   );

   typedef struct {
      logic        ld;
      logic        imm;
      logic [11:0] so;
      logic [31:0] rm;
      logic [31:0] exp;
      int          s;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_lat(input int s);
`ifdef VAL2_BARREL_EN
      exp_lat = 1 + 0 * s;
`else
      exp_lat = s + 1;
`endif
   endfunction

   // Drive an operation and accept it on the next edge; operands are then scrambled.
   task automatic launch(input logic ld, input logic imm, input logic [11:0] so, input logic [31:0] rm);
      LdOrStr = ld; Imm = imm; ShiftOperand = so; RMVal = rm; start = 1'b1;
      tick();
      start = 1'b0;
      RMVal = 32'h5A5A_5A5A; ShiftOperand = 12'h0F0; Imm = ~imm; LdOrStr = ~ld;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      for (int c = 1; c <= 60; c++) begin
         tick();
         if (result_valid) begin
            lat = c;
            break;
         end
      end
   endtask

   initial begin
      int lat, pulses, t1, t2;
      logic [31:0] held;

      vecs[0]  = '{1'b1, 1'b0, 12'hFFC, 32'h0,         32'h0000_0FFC, 0};
      vecs[1]  = '{1'b1, 1'b1, 12'h2FF, 32'h0,         32'h0000_02FF, 0};
      vecs[2]  = '{1'b0, 1'b1, 12'h2FF, 32'h0,         32'hF000_000F, 2};
      vecs[3]  = '{1'b0, 1'b1, 12'h0AB, 32'h0,         32'h0000_00AB, 0};
      vecs[4]  = '{1'b0, 1'b1, 12'h101, 32'h0,         32'h4000_0000, 1};
      vecs[5]  = '{1'b0, 1'b0, 12'h240, 32'h8000_0000, 32'hF800_0000, 4};
      vecs[6]  = '{1'b0, 1'b0, 12'h460, 32'h1234_5678, 32'h7812_3456, 8};
      vecs[7]  = '{1'b0, 1'b0, 12'h200, 32'h0000_00F1, 32'h0000_0F10, 4};
      vecs[8]  = '{1'b0, 1'b0, 12'hFA0, 32'hF000_0000, 32'h0000_0001, 31};
      vecs[9]  = '{1'b0, 1'b0, 12'h060, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0};
      vecs[10] = '{1'b0, 1'b0, 12'h0C0, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 1};
      vecs[11] = '{1'b0, 1'b0, 12'h211, 32'hCAFE_F00D, 32'hCAFE_F00D, 0};
      vecs[12] = '{1'b0, 1'b0, 12'h080, 32'h8000_0001, 32'h0000_0002, 1};

      rst = 1'b1; start = 1'b1; flush = 1'b1; Imm = 1'b0; LdOrStr = 1'b1;
      RMVal = 32'h0; ShiftOperand = 12'h001;
      tick();
      tick();
      rst = 1'b0; start = 1'b0; flush = 1'b0;
      check("reset_result", result, 32'h0);
      check("reset_valid", {31'b0, result_valid}, 32'h0);
      check("reset_busy", {31'b0, busy}, 32'h0);

      for (int i = 0; i < 13; i++) begin
         launch(vecs[i].ld, vecs[i].imm, vecs[i].so, vecs[i].rm);
         check($sformatf("v%0d_busy", i), {31'b0, busy}, 32'h1);
         wait_valid(lat);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].s)));
         check($sformatf("v%0d_result", i), result, vecs[i].exp);
         tick();
         check($sformatf("v%0d_valid_drop", i), {31'b0, result_valid}, 32'h0);
         check($sformatf("v%0d_idle", i), {31'b0, busy}, 32'h0);
         check($sformatf("v%0d_hold", i), result, vecs[i].exp);
      end

      // Back-to-back starts: one result every S+3 cycles.
      LdOrStr = 1'b0; Imm = 1'b1; ShiftOperand = 12'h2FF; start = 1'b1;
      t1 = -1; t2 = -1;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (result_valid) begin
            if (t1 < 0) t1 = c;
            else if (t2 < 0) t2 = c;
         end
      end
      start = 1'b0;
      for (int c = 0; c < 12; c++) tick();
      check("throughput", 32'(t2 - t1), 32'(exp_lat(2) + 2));

      // Second start mid-operation is ignored.
      launch(1'b0, 1'b0, 12'h460, 32'h1234_5678);
      tick();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      pulses = 0;
      held = 32'h0;
      for (int c = 0; c < 20; c++) begin
         if (result_valid) begin
            pulses++;
            held = result;
         end
         tick();
      end
      check("ignored_start_pulses", 32'(pulses), 32'h1);
      check("ignored_start_result", held, 32'h7812_3456);
      check("ignored_start_idle", {31'b0, busy}, 32'h0);

      // Flush mid-operation.
      launch(1'b0, 1'b0, 12'h240, 32'h8000_0000);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_busy", {31'b0, busy}, 32'h0);
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         if (result_valid) pulses++;
         tick();
      end
      check("flush_no_valid", 32'(pulses), 32'h0);
      check("flush_result_kept", result, 32'h7812_3456);

      // Flush in IDLE blocks a simultaneous start.
      LdOrStr = 1'b1; ShiftOperand = 12'h123; start = 1'b1; flush = 1'b1;
      tick();
      start = 1'b0; flush = 1'b0;
      check("flush_idle_block", {31'b0, busy}, 32'h0);

      // Reset mid-operation.
      launch(1'b0, 1'b0, 12'h240, 32'h8000_0000);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_result", result, 32'h0);
      check("midrst_busy", {31'b0, busy}, 32'h0);
      check("midrst_valid", {31'b0, result_valid}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/val2_seq_ctrl.md
VAL2_SEQ_CTRL -- requirements
Module: val2_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request to compute Val2 from the operands sampled on the same edge.
REQ-005 flush  input  1  synchronous abort of the operation in progress.
REQ-006 RMVal  input  32  Rm register value.
REQ-007 Imm  input  1  selects the rotated-immediate form.
REQ-008 LdOrStr  input  1  selects the 12-bit load/store offset form.
REQ-009 ShiftOperand  input  12  shifter operand field.
REQ-010 result  output  32  registered Val2 result.
REQ-011 result_valid  output  1  one-cycle pulse marking a new result.
REQ-012 busy  output  1  high while not IDLE; drives the pipeline stall.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE; busy SHALL equal (state != IDLE).
REQ-014 In IDLE with start=1, the block SHALL load acc, load cnt=S, and enter SHIFT; start SHALL be ignored in SHIFT and DONE.
REQ-015 For LdOrStr=1, base SHALL be {20'b0, ShiftOperand}, S=0.
REQ-016 For Imm=1, LdOrStr=0: base={24'b0, ShiftOperand[7:0]}, S=ShiftOperand[11:8]; each step SHALL rotate acc right by 2 bits.
REQ-017 For Imm=0, LdOrStr=0, ShiftOperand[4]=0: base=RMVal, S=ShiftOperand[11:7]; each step SHALL apply a 1-bit shift of type ShiftOperand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-018 An amount of 0 SHALL return base unchanged for every shift type (no RRX).
REQ-019 ShiftOperand[4]=1 (register-specified shift) is unsupported; the block SHALL return RMVal with S=0.
REQ-020 LdOrStr SHALL take priority over Imm.
REQ-021 In SHIFT with cnt!=0, each edge SHALL perform one step and decrement cnt.
REQ-022 In SHIFT with cnt==0, the edge SHALL write result<=acc, set result_valid=1, and enter DONE.
REQ-023 In DONE, the next edge SHALL clear result_valid and return to IDLE.
REQ-024 Latency: with start accepted at edge k, result_valid SHALL be high in the cycle after edge k+S+1; back-to-back throughput SHALL be one result per S+3 cycles.
REQ-025 result SHALL hold its value until the next completed operation.
REQ-026 flush=1 in SHIFT or DONE SHALL go to IDLE on that edge, clear result_valid, and leave result unchanged; flush in IDLE SHALL block a simultaneous start.
REQ-027 Operands SHALL be sampled only at acceptance; input changes during SHIFT SHALL have no effect.

Reset
REQ-028 rst=1 SHALL force state=IDLE, result=0, result_valid=0, acc=0 and cnt=0 on the next edge, overriding start and flush, including mid-operation.
REQ-029 busy SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-030 Macro VAL2_BARREL_EN: when defined, the full rotate or shift SHALL be computed combinationally at acceptance with S forced to 0, giving latency 1 for all forms.
REQ-031 Without VAL2_BARREL_EN, the iterative step behaviour in REQ-016 to REQ-024 SHALL apply; results SHALL be bit-identical in both builds.

Verification
REQ-032 LdOrStr=1, ShiftOperand=12'hFFC -> result=32'h00000FFC, result_valid high after edge k+1, busy high for 2 cycles.
REQ-033 Imm=1, ShiftOperand=12'h2FF -> result=32'hF000000F after edge k+3 (macro defined: after edge k+1).
REQ-034 Imm=0, RMVal=32'h80000000, ShiftOperand=12'h240 (ASR #4) -> result=32'hF8000000 after edge k+5.
REQ-035 RMVal=32'h12345678, ShiftOperand=12'h460 (ROR #8), with a second start pulsed at edge k+3 -> result=32'h78123456; the second start is ignored, and result_valid pulses exactly once.
REQ-036 Operation from REQ-034 with flush at edge k+2 -> IDLE at edge k+2, no result_valid, result unchanged; repeat with rst at edge k+2 -> result=0 and busy=0.
